// File: rtl/spmv_row_acc_ctrl.sv
// Row-accumulation controller for the SpMV fp16 adder.
// Optional per-row overflow flag: define SPMV_ACC_OVF_FLAG_EN.
module spmv_row_acc_ctrl #(
    parameter int NUM_ROWS = 16,
    parameter int ROW_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    input  logic             s_last,
    output logic [15:0]      o_add_a,
    output logic [15:0]      o_add_b,
    input  logic [15:0]      i_add_sum,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_data,
    output logic [ROW_W-1:0] m_row,
`ifdef SPMV_ACC_OVF_FLAG_EN
    output logic             o_ovf,
`endif
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_t           state_q, state_d;
    logic             mval_q, mval_d;
    logic [15:0]      mdata_q, mdata_d;
    logic [ROW_W-1:0] mrow_q, mrow_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             accept;
    logic             capture;

    assign s_ready = !i_rst && (state_q != FLUSH);
    assign accept  = s_valid && s_ready;
    assign capture = (state_q == FLUSH) && (!mval_q || m_ready);

    // Operand mux: zero on A holds the adder sum when nothing is accepted
    assign o_add_a = accept ? s_data : 16'h0000;
    assign o_add_b = (state_q == IDLE) ? 16'h0000 : i_add_sum;

    assign m_valid = mval_q;
    assign m_data  = mdata_q;
    assign m_row   = mrow_q;
    assign o_done  = mval_q && m_ready && (mrow_q == LAST_ROW);

    // Next-state, output register and row counter update
    always_comb begin
        state_d = state_q;
        mval_d  = mval_q;
        mdata_d = mdata_q;
        mrow_d  = mrow_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = s_last ? FLUSH : ACC;
                end
            end
            ACC: begin
                if (accept && s_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (capture) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (mval_q && m_ready) begin
            mval_d = 1'b0;
        end
        if (capture) begin
            mval_d  = 1'b1;
            mdata_d = i_add_sum;
            mrow_d  = row_q;
            row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            mval_q  <= 1'b0;
            mdata_q <= 16'h0000;
            mrow_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            mval_q  <= mval_d;
            mdata_q <= mdata_d;
            mrow_q  <= mrow_d;
            row_q   <= row_d;
        end
    end

`ifdef SPMV_ACC_OVF_FLAG_EN
    logic ovf_row_q, ovf_row_d;
    logic ovf_q, ovf_d;

    assign o_ovf = ovf_q;

    // Sticky per-row all-ones-exponent flag, restarted by the first product
    always_comb begin
        ovf_row_d = ovf_row_q;
        ovf_d     = ovf_q;
        if (accept) begin
            if (state_q == IDLE) begin
                ovf_row_d = &s_data[14:10];
            end else begin
                ovf_row_d = ovf_row_q | (&s_data[14:10]);
            end
        end
        if (capture) begin
            ovf_d = ovf_row_q | (&i_add_sum[14:10]);
        end
    end

    // Overflow flag registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_row_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_row_q <= ovf_row_d;
            ovf_q     <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_spmv_row_acc_ctrl.sv
// Bench for spmv_row_acc_ctrl: fp16 adder model, row scoreboard,
// and directed vectors with literal expectations.
module tb_spmv_row_acc_ctrl;

    localparam int NUM_ROWS = 16;
    localparam int ROW_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [15:0]      s_data = 16'h0;
    logic             s_last = 1'b0;
    logic [15:0]      o_add_a, o_add_b;
    logic [15:0]      add_sum;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [15:0]      m_data;
    logic [ROW_W-1:0] m_row;
    logic             o_done;
`ifdef SPMV_ACC_OVF_FLAG_EN
    logic             o_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spmv_row_acc_ctrl #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .o_add_a(o_add_a),
        .o_add_b(o_add_b),
        .i_add_sum(add_sum),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_row(m_row),
`ifdef SPMV_ACC_OVF_FLAG_EN
        .o_ovf(o_ovf),
`endif
        .o_done(o_done)
    );

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real a;
        int  e;
        int  m;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        return {s, e[4:0], m[9:0]};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a,
                                         input logic [15:0] b);
        if (a[14:10] == 5'd0) return b;
        if (b[14:10] == 5'd0) return a;
        return r2h(h2r(a) + h2r(b));
    endfunction

    // Registered fp16 adder the controller drives
    always @(posedge clk or posedge rst) begin
        if (rst) add_sum <= 16'h0000;
        else     add_sum <= fadd(o_add_a, o_add_b);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row-level model: running sum per row, queue of finished rows
    logic [15:0]      exp_d[$];
    logic [ROW_W-1:0] exp_r[$];
    logic [15:0]      mdl_sum = 16'h0;
    logic [ROW_W-1:0] mdl_row = '0;
    bit               in_row = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_d.delete();
            exp_r.delete();
            mdl_row = '0;
            in_row  = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_handoff", 1, 0);
                end else begin
                    chk("sb_data", m_data, exp_d[0]);
                    chk("sb_row", m_row, exp_r[0]);
                    chk("sb_done", o_done, exp_r[0] == ROW_W'(NUM_ROWS - 1));
                    void'(exp_d.pop_front());
                    void'(exp_r.pop_front());
                end
                if (o_done) done_cnt++;
            end else begin
                chk("done_idle", o_done, 0);
            end
            if (s_valid && s_ready) begin
                mdl_sum = fadd(s_data, in_row ? mdl_sum : 16'h0000);
                in_row  = 1'b1;
                if (s_last) begin
                    exp_d.push_back(mdl_sum);
                    exp_r.push_back(mdl_row);
                    mdl_row = (mdl_row == ROW_W'(NUM_ROWS - 1)) ? '0 : mdl_row + 1'b1;
                    in_row  = 1'b0;
                end
            end else begin
                chk("add_a_idle", o_add_a, 16'h0000);
            end
        end
    end

    // Present one product, return at posedge+1 after its acceptance edge
    task automatic send(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        s_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        tick(2);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 16'h0000);
        chk("rst_m_row", m_row, 0);
        chk("rst_done", o_done, 0);
        chk("rst_add_a", o_add_a, 16'h0000);
        chk("rst_add_b", o_add_b, 16'h0000);
        tick(2);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 1);

        // Row 0: 1 + 1 + 2 = 4
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        chk("t1_flush_ready", s_ready, 0);
        chk("t1_mvalid_early", m_valid, 0);
        tick(1);
        chk("t1_mvalid", m_valid, 1);
        chk("t1_data", m_data, 16'h4400);
        chk("t1_row", m_row, 0);

        // Single-product row, next row's product 2 cycles later
        send(16'h3800, 1'b1);
        chk("t2_flush_ready", s_ready, 0);
        tick(1);
        chk("t2_data", m_data, 16'h3800);
        chk("t2_ready_back", s_ready, 1);

        // Mixed signs: 3 + (-1) = 2
        send(16'h4200, 1'b0);
        send(16'hBC00, 1'b1);
        tick(1);
        chk("t3_data", m_data, 16'h4000);
        chk("t3_row", m_row, 2);
        tick(1);

        // Backpressure
        do_reset();
        m_ready = 1'b0;
        send(16'h3C00, 1'b1);
        tick(1);
        chk("t4_r0_valid", m_valid, 1);
        send(16'h4000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_stall_ready", s_ready, 0);
            chk("t4_hold_data", m_data, 16'h3C00);
            tick(1);
        end
        m_ready = 1'b1;
        tick(1);
        chk("t4_r1_valid", m_valid, 1);
        chk("t4_r1_data", m_data, 16'h4000);
        chk("t4_r1_row", m_row, 1);
        chk("t4_ready_back", s_ready, 1);
        tick(1);

        // Full pass of 16 rows plus wrap
        do_reset();
        done_cnt = 0;
        for (int r = 0; r < NUM_ROWS; r++) send(16'h3C00, 1'b1);
        tick(3);
        chk("t5_done_cnt", done_cnt, 1);
        send(16'h3C00, 1'b1);
        tick(1);
        chk("t5_wrap_row", m_row, 0);
        tick(1);
        chk("t5_done_once", done_cnt, 1);

        // Reset mid-row discards the partial sum
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        do_reset();
        send(16'h3800, 1'b1);
        tick(1);
        chk("t6_data", m_data, 16'h3800);
        chk("t6_row", m_row, 0);
`ifdef SPMV_ACC_OVF_FLAG_EN
        chk("t6_ovf_clear", o_ovf, 0);
        send(16'h7C00, 1'b1);
        tick(1);
        chk("t6_ovf", o_ovf, 1);
`endif
        tick(3);
        chk("sb_drained", exp_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmv_row_acc_ctrl.md
# spmv_row_acc_ctrl

Row-accumulation controller for the SpMV fp16 adder. It accepts a stream of fp16 partial products, one row at a time, and drives the operands of the registered fp16 adder instance so that each row is reduced to a single sum. It captures each finished row sum into a one-entry output register with a valid/ready handshake and tracks the row index across the matrix. It sits between the fp16 multiplier stream and the result write-back.

## Interface
- NUM_ROWS, 16, rows per matrix pass; row index wraps after NUM_ROWS-1
- ROW_W, 4, width of row index (≥ clog2(NUM_ROWS))
- i_clk  input  1  clock; all state on rising edge
- i_rst  input  1  asynchronous, active-high reset; parent drives adder's active-low reset with ~i_rst
- s_valid  input  1  product valid
- s_ready  output  1  product accepted when s_valid && s_ready
- s_data  input  16  fp16 product
- s_last  input  1  marks final product of current row
- o_add_a  output  16  adder operand A (mul side)
- o_add_b  output  16  adder operand B (accumulator side)
- i_add_sum  input  16  adder registered result (1-cycle latency)
- m_valid  output  1  row sum valid
- m_ready  input  1  consumer accepts row sum
- m_data  output  16  fp16 row sum
- m_row  output  ROW_W  index of row in m_data
- o_done  output  1  one-cycle pulse when row NUM_ROWS-1 is handed off (m_valid && m_ready)

## Operation
- States: IDLE (no product of current row accepted yet), ACC (row in progress), FLUSH (waiting to capture final sum).
- Operand mux (combinational):
  - Accepting: o_add_a = s_data; o_add_b = 16'h0000 in IDLE, i_add_sum in ACC.
  - Not accepting: o_add_a = 16'h0000 (adder treats zero exponent as pass-through); o_add_b = 16'h0000 in IDLE, i_add_sum in ACC/FLUSH, so the sum holds.
- s_ready = 1 in IDLE and ACC; 0 in FLUSH and during reset.
- Transitions:
  - IDLE, accept, !s_last -> ACC.
  - IDLE, accept, s_last -> FLUSH (single-product row).
  - ACC, accept, s_last -> FLUSH.
  - FLUSH, (!m_valid || m_ready) -> capture m_data <= i_add_sum, m_row <= row counter, m_valid <= 1, row counter increments (wraps NUM_ROWS-1 -> 0), -> IDLE.
  - FLUSH otherwise: stay; operands keep the adder holding the sum.
- m_valid clears on m_valid && m_ready unless a capture occurs in the same cycle (capture wins, m_valid stays 1).
- No arithmetic is performed in this block; numerics are the adder's (zero exponent = zero, no inf/NaN handling).
- Reset mid-row: partial sum discarded, state IDLE, row counter 0, m_valid 0.

## Timing
- Reset values: s_ready 0 while i_rst high, then 1; m_valid 0, m_data 0, m_row 0, o_done 0; o_add_a/o_add_b 0.
- Product accepted in cycle t is reflected in i_add_sum in cycle t+1; back-to-back acceptance at one product per cycle.
- Last accepted in cycle t: FLUSH in t+1; m_valid high from t+2 if output register free; s_ready high again in t+2.
- Row of L products occupies L+1 cycles of input bandwidth (one FLUSH bubble).
- Output backpressure stalls only in FLUSH; the next row is not accepted until capture.

## Configuration
- SPMV_ACC_OVF_FLAG_EN defined: adds output o_ovf (1 bit, reset 0), registered alongside m_data. Set when any accepted product or captured sum of the row has exponent 5'b11111. Sticky per row, cleared on row start.
- Undefined: port absent, no extra logic.

## Test plan
- Row 3C00, 3C00, 4000 (last), m_ready=1 -> m_data=4400, m_row=0, m_valid asserted 2 cycles after last accepted.
- Single product 3800 with s_last -> m_data=3800; next row's first product accepted 2 cycles later.
- Mixed signs 4200, BC00 (last) -> m_data=4000.
- Backpressure: m_ready=0 with row 0 pending, row 1 = 4000 (last) -> s_ready low in FLUSH until m_ready; row 1 sum 4000 captured on handoff cycle, m_row=1.
- 16 rows of 3C00 each -> m_row 0..15, o_done pulses once with row 15, next row m_row=0.
- Reset asserted after 2 products of a row, then row 3800 (last) -> m_data=3800, m_row=0; with SPMV_ACC_OVF_FLAG_EN, row 7C00 (last) -> o_ovf=1.
